// File: rtl/mc_mips_pkg.sv
// rtl/mc_mips_pkg.sv - shared opcodes, funct codes, FSM states and ALU ops for mc_mips_core
package mc_mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_t;

  // 32-bit wrapping ALU; slt compares as signed
  function automatic logic [31:0] alu_eval(input alu_op_t op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] res;
    case (op)
      ALU_SUB: res = a - b;
      ALU_AND: res = a & b;
      ALU_OR:  res = a | b;
      ALU_SLT: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: res = a + b;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mc_mips_core_if.sv
// rtl/mc_mips_core_if.sv - unified variable-latency memory port with req/ready handshake
interface mc_mips_core_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mc_control.sv
// rtl/mc_control.sv - multi-cycle FSM: state register, next-state logic and control decode
module mc_control
  import mc_mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  input  logic       i_mem_ready,
  input  logic       i_a_eq_b,
  output state_t     o_state,
  output logic       o_mem_req,
  output logic       o_mem_we,
  output logic       o_retire,
  output logic       o_halted,
  output logic       o_fetch_done,
  output logic       o_mem_done,
  output logic       o_pc_branch,
  output logic       o_pc_jump,
  output logic       o_rf_we,
  output logic       o_wb_rd,
  output logic       o_wb_mdr,
  output logic       o_alu_src_imm,
  output alu_op_t    o_alu_op
);

  state_t  r_state;
  logic    r_mem_req;
  logic    r_mem_we;
  logic    r_halted;

  logic    w_is_r;
  logic    w_r_ok;
  logic    w_is_addi;
  logic    w_is_lw;
  logic    w_is_sw;
  logic    w_is_beq;
  logic    w_is_bne;
  logic    w_is_j;
  logic    w_legal;
  alu_op_t w_alu_op;

  assign w_is_r    = (i_opcode == OP_RTYPE);
  assign w_is_addi = (i_opcode == OP_ADDI);
  assign w_is_lw   = (i_opcode == OP_LW);
  assign w_is_sw   = (i_opcode == OP_SW);
  assign w_is_beq  = (i_opcode == OP_BEQ);
  assign w_is_bne  = (i_opcode == OP_BNE);
  assign w_is_j    = (i_opcode == OP_J);

  // R-type legality and ALU operation selected from funct
  always_comb begin
    w_r_ok   = 1'b0;
    w_alu_op = ALU_ADD;
    if (w_is_r) begin
      case (i_funct)
        FN_ADD: begin w_r_ok = 1'b1; w_alu_op = ALU_ADD; end
        FN_SUB: begin w_r_ok = 1'b1; w_alu_op = ALU_SUB; end
        FN_AND: begin w_r_ok = 1'b1; w_alu_op = ALU_AND; end
        FN_OR:  begin w_r_ok = 1'b1; w_alu_op = ALU_OR;  end
        FN_SLT: begin w_r_ok = 1'b1; w_alu_op = ALU_SLT; end
        default: begin w_r_ok = 1'b0; w_alu_op = ALU_ADD; end
      endcase
    end
  end

  assign w_legal = w_r_ok | w_is_addi | w_is_lw | w_is_sw | w_is_beq | w_is_bne | w_is_j;

  // State sequencing; mem_req/mem_we are prepared one edge ahead of FETCH/MEM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_FETCH;
      r_mem_req <= 1'b1;
      r_mem_we  <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (i_mem_ready) begin
            r_state   <= ST_DECODE;
            r_mem_req <= 1'b0;
          end
        end
        ST_DECODE: begin
          if (!w_legal) begin
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
          end else begin
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (w_is_lw || w_is_sw) begin
            r_state   <= ST_MEM;
            r_mem_req <= 1'b1;
            r_mem_we  <= w_is_sw;
          end else if (w_is_beq || w_is_bne || w_is_j) begin
            r_state   <= ST_FETCH;
            r_mem_req <= 1'b1;
          end else begin
            r_state <= ST_WB;
          end
        end
        ST_MEM: begin
          if (i_mem_ready) begin
            r_mem_we <= 1'b0;
            if (w_is_sw) begin
              r_state   <= ST_FETCH;
              r_mem_req <= 1'b1;
            end else begin
              r_state   <= ST_WB;
              r_mem_req <= 1'b0;
            end
          end
        end
        ST_WB: begin
          r_state   <= ST_FETCH;
          r_mem_req <= 1'b1;
        end
        default: begin
          r_state   <= ST_HALT;
          r_mem_req <= 1'b0;
          r_mem_we  <= 1'b0;
        end
      endcase
    end
  end

  assign o_state       = r_state;
  assign o_mem_req     = r_mem_req & reset;
  assign o_mem_we      = r_mem_we;
  assign o_halted      = r_halted;
  assign o_fetch_done  = (r_state == ST_FETCH) & i_mem_ready;
  assign o_mem_done    = (r_state == ST_MEM) & i_mem_ready;
  assign o_pc_branch   = (r_state == ST_EXEC) & ((w_is_beq & i_a_eq_b) | (w_is_bne & ~i_a_eq_b));
  assign o_pc_jump     = (r_state == ST_EXEC) & w_is_j;
  assign o_rf_we       = (r_state == ST_WB);
  assign o_wb_rd       = w_is_r;
  assign o_wb_mdr      = w_is_lw;
  assign o_alu_src_imm = ~w_is_r;
  assign o_alu_op      = w_alu_op;
  // A store completes in the cycle its transfer is accepted, so its retire follows mem_ready
  assign o_retire      = (r_state == ST_WB)
                       | ((r_state == ST_EXEC) & (w_is_beq | w_is_bne | w_is_j))
                       | ((r_state == ST_MEM) & w_is_sw & i_mem_ready);

endmodule

// File: rtl/mc_mips_core.sv
// rtl/mc_mips_core.sv - multi-cycle MIPS core datapath; MC_RETIRE_CNT_EN adds retire_count
module mc_mips_core
  import mc_mips_pkg::*;
#(
  parameter int          NREG     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  mc_mips_core_if.master     bus,
  output logic               retire,
  output logic               halted,
  output logic [31:0]        dbg_pc
`ifdef MC_RETIRE_CNT_EN
  ,
  output logic [31:0]        retire_count
`endif
);

  localparam int RW = $clog2(NREG);

  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_alu_out;
  logic [31:0] r_mdr;
  logic [31:0] r_rf [NREG];

  state_t      w_state;
  logic        w_mem_req;
  logic        w_mem_we;
  logic        w_retire;
  logic        w_halted;
  logic        w_fetch_done;
  logic        w_mem_done;
  logic        w_pc_branch;
  logic        w_pc_jump;
  logic        w_rf_we;
  logic        w_wb_rd;
  logic        w_wb_mdr;
  logic        w_alu_src_imm;
  alu_op_t     w_alu_op;

  logic [RW-1:0] w_rs_idx;
  logic [RW-1:0] w_rt_idx;
  logic [RW-1:0] w_rd_idx;
  logic [RW-1:0] w_wr_idx;
  logic [31:0]   w_rs_val;
  logic [31:0]   w_rt_val;
  logic [31:0]   w_imm_sext;
  logic [31:0]   w_alu_res;

  mc_control u_control (
    .clk           (clk),
    .reset         (reset),
    .i_opcode      (r_ir[31:26]),
    .i_funct       (r_ir[5:0]),
    .i_mem_ready   (bus.mem_ready),
    .i_a_eq_b      (r_a == r_b),
    .o_state       (w_state),
    .o_mem_req     (w_mem_req),
    .o_mem_we      (w_mem_we),
    .o_retire      (w_retire),
    .o_halted      (w_halted),
    .o_fetch_done  (w_fetch_done),
    .o_mem_done    (w_mem_done),
    .o_pc_branch   (w_pc_branch),
    .o_pc_jump     (w_pc_jump),
    .o_rf_we       (w_rf_we),
    .o_wb_rd       (w_wb_rd),
    .o_wb_mdr      (w_wb_mdr),
    .o_alu_src_imm (w_alu_src_imm),
    .o_alu_op      (w_alu_op)
  );

  // Register indices use only the low log2(NREG) bits of each field
  assign w_rs_idx   = r_ir[21 +: RW];
  assign w_rt_idx   = r_ir[16 +: RW];
  assign w_rd_idx   = r_ir[11 +: RW];
  assign w_wr_idx   = w_wb_rd ? w_rd_idx : w_rt_idx;
  assign w_rs_val   = (w_rs_idx == '0) ? 32'd0 : r_rf[w_rs_idx];
  assign w_rt_val   = (w_rt_idx == '0) ? 32'd0 : r_rf[w_rt_idx];
  assign w_imm_sext = {{16{r_ir[15]}}, r_ir[15:0]};
  assign w_alu_res  = alu_eval(w_alu_op, r_a, w_alu_src_imm ? w_imm_sext : r_b);

  // Datapath registers advance according to the current FSM state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc      <= RESET_PC;
      r_ir      <= 32'd0;
      r_a       <= 32'd0;
      r_b       <= 32'd0;
      r_alu_out <= 32'd0;
      r_mdr     <= 32'd0;
    end else begin
      case (w_state)
        ST_FETCH: begin
          if (w_fetch_done) begin
            r_ir <= bus.mem_rdata;
            r_pc <= r_pc + 32'd4;
          end
        end
        ST_DECODE: begin
          r_a       <= w_rs_val;
          r_b       <= w_rt_val;
          r_alu_out <= r_pc + {w_imm_sext[29:0], 2'b00};
        end
        ST_EXEC: begin
          if (w_pc_branch) begin
            r_pc <= r_alu_out;
          end else if (w_pc_jump) begin
            r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
          end else begin
            r_alu_out <= w_alu_res;
          end
        end
        ST_MEM: begin
          if (w_mem_done) begin
            r_mdr <= bus.mem_rdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Register file write-back; $0 is never written
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_rf[i] <= 32'd0;
      end
    end else if (w_rf_we && (w_wr_idx != '0)) begin
      r_rf[w_wr_idx] <= w_wb_mdr ? r_mdr : r_alu_out;
    end
  end

  assign bus.mem_req   = w_mem_req;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_addr  = (w_state == ST_MEM) ? r_alu_out : r_pc;
  assign bus.mem_wdata = r_b;

  assign retire = w_retire;
  assign halted = w_halted;
  assign dbg_pc = r_pc;

`ifdef MC_RETIRE_CNT_EN
  logic [31:0] r_retire_count;

  // Count retired instructions, frozen once the core halts
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_retire_count <= 32'd0;
    end else if (w_retire && !w_halted) begin
      r_retire_count <= r_retire_count + 32'd1;
    end
  end

  assign retire_count = r_retire_count;
`endif

endmodule

// File: tb/tb_mc_mips_core.sv
// tb/tb_mc_mips_core.sv - scoreboard bench for mc_mips_core (bus transactions, retire timing, halt, reset)
module tb_mc_mips_core;

  localparam logic [31:0] ILLEGAL = 32'hFC00_0000;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } bus_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        retire;
  logic        halted;
  logic [31:0] dbg_pc;
  logic        mem_ready;
  logic [31:0] mem [0:1023];
  int          stall = 0;
  int          wcnt = 0;
`ifdef MC_RETIRE_CNT_EN
  logic [31:0] retire_count;
`endif

  bus_t exp_q[$];
  bus_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   n_retire = 0;
  int   first_retire = 0;
  int   last_retire = 0;

  mc_mips_core_if bus ();

  mc_mips_core #(.NREG(32), .RESET_PC(32'h0)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .retire       (retire),
    .halted       (halted),
    .dbg_pc       (dbg_pc)
`ifdef MC_RETIRE_CNT_EN
    ,
    .retire_count (retire_count)
`endif
  );

  always #5 clk = ~clk;

  assign mem_ready     = (wcnt >= stall);
  assign bus.mem_ready = mem_ready;
  assign bus.mem_rdata = mem[bus.mem_addr[11:2]];

  // Memory responder: wait-state counter and store write
  always @(posedge clk) begin
    if (!reset) begin
      wcnt <= 0;
    end else if (bus.mem_req) begin
      wcnt <= mem_ready ? 0 : wcnt + 1;
      if (mem_ready && bus.mem_we) mem[bus.mem_addr[11:2]] = bus.mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Monitor: retire timing and scoreboard of every bus cycle
  always @(negedge clk) begin
    if (reset) begin
      cyc++;
      if (retire) begin
        n_retire++;
        if (first_retire == 0) first_retire = cyc;
        last_retire = cyc;
      end
      if (bus.mem_req) begin
        if (exp_q.size() == 0) begin
          check("bus_extra_req", 32'(exp_q.size()), 32'd1);
        end else begin
          mon_e = exp_q[0];
          check(mem_ready ? "bus_addr" : "bus_addr_hold", bus.mem_addr, mon_e.addr);
          check("bus_we", {31'd0, bus.mem_we}, {31'd0, mon_e.we});
          if (mon_e.we) check("bus_wdata", bus.mem_wdata, mon_e.data);
          if (mem_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] t);
    return {6'h02, t};
  endfunction

  task automatic push_rd(input logic [31:0] a);
    bus_t e;
    e.we = 1'b0; e.addr = a; e.data = 32'd0;
    exp_q.push_back(e);
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    bus_t e;
    e.we = 1'b1; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic start_reset(input int wait_states);
    reset = 1'b0;
    exp_q.delete();
    stall = wait_states;
    for (int i = 0; i < 1024; i++) mem[i] = ILLEGAL;
    repeat (3) @(posedge clk);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc = 0;
    n_retire = 0;
    first_retire = 0;
    last_retire = 0;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic end_test(input string tag, input int exp_retires);
    check({tag, "_halted"}, {31'd0, halted}, 32'd1);
    check({tag, "_req_idle"}, {31'd0, bus.mem_req}, 32'd0);
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_retires"}, 32'(n_retire), 32'(exp_retires));
`ifdef MC_RETIRE_CNT_EN
    check({tag, "_retire_count"}, retire_count, 32'(exp_retires));
`endif
  endtask

  logic [31:0] alu_vals [5];

  initial begin
    // Reset state, then addi/add/sw with zero-wait memory
    start_reset(0);
    mem[0] = enc_i(6'h08, 0, 1, 16'd5);
    mem[1] = enc_r(6'h20, 1, 1, 2);
    mem[2] = enc_i(6'h2B, 0, 2, 16'h0040);
    push_rd(32'h0); push_rd(32'h4); push_rd(32'h8);
    push_wr(32'h40, 32'd10); push_rd(32'hC);
    @(negedge clk);
    check("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    check("rst_retire", {31'd0, retire}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_dbg_pc", dbg_pc, 32'h0);
    release_reset();
    run(1);
    check("first_req", {31'd0, bus.mem_req}, 32'd1);
    check("first_addr", bus.mem_addr, 32'h0);
    check("first_we", {31'd0, bus.mem_we}, 32'd0);
    run(11);
    check("seq_retires_12cyc", 32'(n_retire), 32'd3);
    check("seq_last_retire_cyc", 32'(last_retire), 32'd12);
    run(10);
    check("seq_mem40", mem[16], 32'd10);
    end_test("seq", 3);

    // lw with 3 wait states on both fetch and data access
    start_reset(3);
    mem[0] = enc_i(6'h23, 0, 5, 16'h0080);
    mem[1] = enc_i(6'h2B, 0, 5, 16'h0084);
    mem[32] = 32'hDEAD_BEEF;
    push_rd(32'h0); push_rd(32'h80); push_rd(32'h4);
    push_wr(32'h84, 32'hDEAD_BEEF); push_rd(32'h8);
    release_reset();
    run(11);
    check("lw_retire_cyc", 32'(first_retire), 32'd11);
    run(30);
    end_test("lw", 2);

    // beq taken backwards: 0x10 -> 0x0C
    start_reset(0);
    mem[0] = enc_i(6'h08, 0, 1, 16'd3);
    mem[1] = enc_j(26'h4);
    mem[4] = enc_i(6'h04, 1, 1, 16'hFFFE);
    push_rd(32'h0); push_rd(32'h4); push_rd(32'h10); push_rd(32'hC);
    release_reset();
    run(20);
    end_test("beq", 3);

    // bne not taken: 0x10 -> 0x14
    start_reset(0);
    mem[0] = enc_i(6'h08, 0, 1, 16'd3);
    mem[1] = enc_j(26'h4);
    mem[4] = enc_i(6'h05, 1, 1, 16'hFFFE);
    push_rd(32'h0); push_rd(32'h4); push_rd(32'h10); push_rd(32'h14);
    release_reset();
    run(20);
    end_test("bne", 3);

    // Jump to 0x400, $0 write dropped, $3 = $0 + $0
    start_reset(0);
    mem[0]   = enc_j(26'h8);
    mem[8]   = enc_j(26'h100);
    mem[256] = enc_i(6'h08, 0, 0, 16'd7);
    mem[257] = enc_r(6'h20, 0, 0, 3);
    mem[258] = enc_i(6'h2B, 0, 3, 16'h0044);
    mem[17]  = 32'hFFFF_FFFF;
    push_rd(32'h0); push_rd(32'h20); push_rd(32'h400); push_rd(32'h404);
    push_rd(32'h408); push_wr(32'h44, 32'd0); push_rd(32'h40C);
    release_reset();
    run(30);
    check("jmp_mem44", mem[17], 32'd0);
    end_test("jmp", 5);

    // ALU ops with a negative operand; results stored to 0x100..0x110
    start_reset(0);
    alu_vals[0] = 32'hFFFF_FFFD - 32'd5;
    alu_vals[1] = 32'hFFFF_FFFD & 32'd5;
    alu_vals[2] = 32'hFFFF_FFFD | 32'd5;
    alu_vals[3] = 32'd1;
    alu_vals[4] = 32'd0;
    mem[0] = enc_i(6'h08, 0, 1, 16'hFFFD);
    mem[1] = enc_i(6'h08, 0, 2, 16'd5);
    mem[2] = enc_r(6'h22, 1, 2, 3);
    mem[3] = enc_r(6'h24, 1, 2, 4);
    mem[4] = enc_r(6'h25, 1, 2, 5);
    mem[5] = enc_r(6'h2A, 1, 2, 6);
    mem[6] = enc_r(6'h2A, 2, 1, 7);
    for (int k = 0; k < 5; k++) mem[7 + k] = enc_i(6'h2B, 0, 5'(3 + k), 16'(32'h100 + 4 * k));
    for (int i = 0; i < 7; i++) push_rd(32'(4 * i));
    for (int k = 0; k < 5; k++) begin
      push_rd(32'(32'h1C + 4 * k));
      push_wr(32'(32'h100 + 4 * k), alu_vals[k]);
    end
    push_rd(32'h30);
    release_reset();
    run(60);
    end_test("alu", 12);

    // Illegal R-type funct halts
    start_reset(0);
    mem[0] = enc_r(6'h00, 1, 2, 3);
    push_rd(32'h0);
    release_reset();
    run(8);
    end_test("ill_funct", 0);

    // Illegal opcode: halted after DECODE, then reset clears it
    start_reset(0);
    mem[0] = ILLEGAL;
    push_rd(32'h0);
    release_reset();
    run(2);
    check("ill_halted_decode", {31'd0, halted}, 32'd0);
    run(1);
    check("ill_halted_set", {31'd0, halted}, 32'd1);
    run(5);
    end_test("ill_op", 0);
    start_reset(6);
    check("rst_clears_halted", {31'd0, halted}, 32'd0);

    // Reset during a waiting MEM access aborts it and restarts at RESET_PC
    mem[0] = enc_i(6'h23, 0, 5, 16'h0080);
    mem[1] = enc_i(6'h2B, 0, 5, 16'h0084);
    mem[32] = 32'h1234_5678;
    push_rd(32'h0); push_rd(32'h80);
    release_reset();
    run(12);
    check("abort_in_mem_req", {31'd0, bus.mem_req}, 32'd1);
    check("abort_in_mem_addr", bus.mem_addr, 32'h80);
    reset = 1'b0;
    #1;
    check("abort_req_gated", {31'd0, bus.mem_req}, 32'd0);
    check("abort_dbg_pc", dbg_pc, 32'h0);
    check("abort_retire", {31'd0, retire}, 32'd0);
    exp_q.delete();
    stall = 0;
    push_rd(32'h0); push_rd(32'h80); push_rd(32'h4);
    push_wr(32'h84, 32'h1234_5678); push_rd(32'h8);
    repeat (2) @(posedge clk);
    release_reset();
    run(5);
    check("restart_lw_retire_cyc", 32'(first_retire), 32'd5);
    run(20);
    end_test("restart", 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
